// File: rtl/icache_line_fill.sv
// Instruction-cache line fill engine.
// On a miss it latches the line address, bursts four 64-bit beats from memory
// into a 256-bit line buffer, writes the line and tag into the arrays, then
// pulses fill_done for one cycle.
//
// Build option ICACHE_FILL_EARLY_WRITE_EN:
//   undefined - the whole line is written in one go in the WRITE cycle.
//   defined   - each beat is written to its 8-byte slot as it arrives. The
//               WRITE cycle then only strobes the tag.
// The ports, the state sequence and the latency are the same in both builds.
module icache_line_fill (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_req,
  input  logic [31:0]  miss_addr,
  output logic         fill_busy,
  output logic         fill_done,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [63:0]  pmem_rdata,
  output logic [31:0]  dataw_en,
  output logic [5:0]   dataw_index,
  output logic [255:0] dataw_line,
  output logic         tag_we,
  output logic [20:0]  tag_out
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWrite,
    StDone
  } state_e;

  state_e       state_q, state_d;
  // Holds miss_addr[31:5]. Bits [5:0] of this register are the set index.
  // Bits [26:6] of this register are the tag.
  logic [26:0]  line_addr_q, line_addr_d;
  logic [1:0]   beat_q, beat_d;
  logic [255:0] line_q, line_d;

  // Next-state logic: latch the miss, collect the beats, then write and finish.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    beat_d      = beat_q;
    line_d      = line_q;
    unique case (state_q)
      StIdle: begin
        if (miss_req) begin
          line_addr_d = miss_addr[31:5];
          state_d     = StFetch;
        end
      end
      StFetch: begin
        // Memory may stall for any number of cycles. Nothing moves until a beat arrives.
        if (pmem_resp) begin
          line_d[{beat_q, 6'b0} +: 64] = pmem_rdata;
          beat_d                       = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      line_addr_q <= '0;
      beat_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
    end
  end

  // Control outputs are gated by rst_n.
  // This blocks array and tag writes in a cycle that is being reset.
  always_comb begin
    fill_busy    = rst_n && (state_q != StIdle);
    fill_done    = rst_n && (state_q == StDone);
    pmem_read    = rst_n && (state_q == StFetch);
    tag_we       = rst_n && (state_q == StWrite);
    pmem_address = rst_n ? {line_addr_q, 5'b0} : 32'h0;
    dataw_index  = line_addr_q[5:0];
    tag_out      = line_addr_q[26:6];
  end

`ifdef ICACHE_FILL_EARLY_WRITE_EN
  // Each incoming beat goes straight to its byte lanes.
  // The data is taken combinationally from pmem_rdata.
  always_comb begin
    dataw_en   = 32'h0;
    dataw_line = line_q;
    if (rst_n && (state_q == StFetch) && pmem_resp) begin
      dataw_en                         = 32'hFF << {beat_q, 3'b0};
      dataw_line[{beat_q, 6'b0} +: 64] = pmem_rdata;
    end
  end
`else
  // The assembled line is written all at once in the WRITE cycle.
  always_comb begin
    dataw_line = line_q;
    dataw_en   = (rst_n && (state_q == StWrite)) ? 32'hFFFF_FFFF : 32'h0;
  end
`endif

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port miss_req  in  1  request to fill one line; sampled only in IDLE.
REQ-004 SHALL have port miss_addr  in  32  byte address of missing instruction.
REQ-005 SHALL have port fill_busy  out  1  high in every state except IDLE.
REQ-006 SHALL have port fill_done  out  1  one-cycle pulse when the line and tag are written.
REQ-007 SHALL have port pmem_read  out  1  burst read request to memory.
REQ-008 SHALL have port pmem_address  out  32  line-aligned address, {miss_addr[31:5], 5'b0}.
REQ-009 SHALL have port pmem_resp  in  1  one 64-bit beat valid this cycle.
REQ-010 SHALL have port pmem_rdata  in  64  beat data, beat 0 = bytes 0-7 of the line.
REQ-011 SHALL have port dataw_en  out  32  per-byte write enable to the 64x256 data array.
REQ-012 SHALL have port dataw_index  out  6  set index, latched miss_addr[10:5].
REQ-013 SHALL have port dataw_line  out  256  write data to the data array.
REQ-014 SHALL have port tag_we  out  1  tag/valid write strobe.
REQ-015 SHALL have port tag_out  out  21  latched miss_addr[31:11].

Function
REQ-016 SHALL implement states IDLE, FETCH, WRITE, DONE.
REQ-017 IDLE: on miss_req=1 SHALL latch miss_addr and enter FETCH next cycle; otherwise stay.
REQ-018 FETCH: pmem_read SHALL be 1 every cycle in FETCH and 0 in all other states.
REQ-019 FETCH: each cycle with pmem_resp=1 SHALL store pmem_rdata into line buffer bits [64*beat +: 64] and increment 2-bit beat counter.
REQ-020 FETCH: on pmem_resp=1 with beat=3 SHALL enter WRITE; beat counter wraps to 0.
REQ-021 FETCH: cycles with pmem_resp=0 SHALL hold all state (arbitrary memory stall length).
REQ-022 WRITE: one cycle; tag_we=1; data write per Configuration; then DONE.
REQ-023 DONE: fill_done=1 for exactly one cycle, then IDLE; miss_req in DONE SHALL be ignored.
REQ-024 miss_req while fill_busy=1 SHALL be ignored; requester holds it until fill_done.
REQ-025 pmem_resp outside FETCH SHALL be ignored and not change state.
REQ-026 dataw_en SHALL be 32'h0 in every cycle not named in REQ-022/REQ-033.
REQ-027 Minimum latency: miss_req cycle 0, pmem_read cycle 1, zero-stall beats cycles 1-4, WRITE cycle 5, fill_done cycle 6.
REQ-028 pmem_address, dataw_index, tag_out SHALL remain stable from FETCH entry until IDLE re-entry.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, beat=0, line buffer and latched address to 0.
REQ-030 While in reset and the cycle after: fill_busy, fill_done, pmem_read, tag_we=0, dataw_en=32'h0, pmem_address=0.
REQ-031 Reset mid-FETCH/WRITE SHALL abandon the fill with no further array or tag write.

Configuration
REQ-032 Macro ICACHE_FILL_EARLY_WRITE_EN absent: WRITE SHALL drive dataw_en=32'hFFFF_FFFF and dataw_line=assembled line.
REQ-033 ICACHE_FILL_EARLY_WRITE_EN defined: each FETCH cycle with pmem_resp=1 SHALL drive dataw_en=32'hFF<<(8*beat) and pmem_rdata at slot beat of dataw_line (combinational from pmem_rdata); WRITE SHALL drive dataw_en=32'h0, tag_we=1 only.
REQ-034 Port list, state sequence and latency SHALL be identical in both builds.

Verification
REQ-035 miss_addr=32'h0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 back-to-back -> pmem_address=32'h0000_1220, dataw_index=6'h11, tag_out=21'h2, fill_done cycle 6, line 0x44..44_33..33_22..22_11..11.
REQ-036 Two idle cycles between each beat -> pmem_read held high throughout, fill_done cycle 12, same line.
REQ-037 miss_req asserted with new address during FETCH -> ignored; tag_out and pmem_address unchanged.
REQ-038 rst_n=0 after beat 2 -> next cycle IDLE, all outputs 0, no dataw_en or tag_we ever asserted.
REQ-039 Early-write build, beat 2=0xAB..AB -> that cycle dataw_en=32'h00FF_0000, dataw_line[191:128]=0xAB..AB.
REQ-040 pmem_resp pulsed in IDLE -> no state change, fill_busy stays 0.
